// File: rtl/gmii_pkg.sv
// Shared types and constants for the GMII receive path.
package gmii_pkg;

  typedef enum logic [1:0] {
    ST_DROP     = 2'd0,
    ST_IDLE     = 2'd1,
    ST_PREAMBLE = 2'd2,
    ST_DATA     = 2'd3
  } rx_state_e;

  // One registered output beat of the payload stream.
  typedef struct packed {
    logic        valid;
    logic [7:0]  data;
    logic        sop;
    logic        eop;
    logic        err;
    logic [15:0] len;
  } rx_beat_t;

  localparam logic [7:0] PREAMBLE_BYTE    = 8'h55;
  localparam logic [7:0] DEF_SFD_BYTE     = 8'h5D;
  localparam int         DEF_MIN_PREAMBLE = 1;
  localparam int         DEF_MIN_LEN      = 14;
  localparam int         DEF_MAX_LEN      = 1522;
  localparam logic [3:0] PRE_CNT_MAX      = 4'hF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/gmii_rx_stats.sv
// Frame and error statistics: two free-running 32-bit counters that wrap.
module gmii_rx_stats (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        frame_inc_i,
  input  logic        err_inc_i,
  output logic [31:0] frame_cnt_o,
  output logic [31:0] err_cnt_o
);

  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic [31:0] err_cnt_q, err_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q + {31'd0, frame_inc_i};
    err_cnt_d   = err_cnt_q + {31'd0, err_inc_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign frame_cnt_o = frame_cnt_q;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: rtl/gmii_rx_deframer.sv
// GMII receive deframer: strips preamble/SFD and emits the payload as a
// sop/eop-delimited byte stream with length and error status.
module gmii_rx_deframer
  import gmii_pkg::*;
#(
  parameter logic [7:0] SFD_BYTE     = DEF_SFD_BYTE,
  parameter int         MIN_PREAMBLE = DEF_MIN_PREAMBLE,
  parameter int         MIN_LEN      = DEF_MIN_LEN,
  parameter int         MAX_LEN      = DEF_MAX_LEN
) (
  input  logic        gmii_rxclk,
  input  logic        rst,
  input  logic        gmii_rxctrl,
  input  logic [7:0]  gmii_rxdata,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  output logic        rx_sop,
  output logic        rx_eop,
  output logic        rx_err,
  output logic [15:0] rx_len,
  output logic [31:0] frame_cnt,
  output logic [31:0] err_cnt
);

  localparam logic [15:0] MIN_LEN_W = 16'(MIN_LEN);
  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);
  localparam logic [15:0] MIN_PRE_W = 16'(MIN_PREAMBLE);

  logic        s1_ctrl_q, s1_vld_q;
  logic [7:0]  s1_data_q;
  rx_state_e   state_q, state_d;
  logic [3:0]  pre_cnt_q, pre_cnt_d;
  logic [15:0] len_q, len_d;
  logic        first_q, first_d;
  logic [7:0]  hold_q, hold_d;
  rx_beat_t    out_q, out_d;
  logic        frame_inc, err_inc;
  logic        pre_ok, len_err;

  assign pre_ok  = {12'd0, pre_cnt_q} >= MIN_PRE_W;
  assign len_err = (len_q < MIN_LEN_W) || (len_q > MAX_LEN_W);

  // NOTE: every signal driven here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    len_d     = len_q;
    first_d   = first_q;
    hold_d    = hold_q;
    out_d     = '0;
    frame_inc = 1'b0;
    err_inc   = 1'b0;

    unique case (state_q)
      ST_DROP: begin
        // s1 right after reset holds no real sample, so it cannot end a frame.
        if (s1_vld_q && !s1_ctrl_q) state_d = ST_IDLE;
      end

      ST_IDLE: begin
        if (s1_ctrl_q) begin
          if (s1_data_q == PREAMBLE_BYTE) begin
            state_d   = ST_PREAMBLE;
            pre_cnt_d = 4'd1;
          end else if (s1_data_q == SFD_BYTE && MIN_PREAMBLE == 0) begin
            state_d = ST_DATA;
            len_d   = 16'd0;
            first_d = 1'b1;
          end else begin
            state_d = ST_DROP;
            err_inc = 1'b1;
          end
        end
      end

      ST_PREAMBLE: begin
        if (!s1_ctrl_q) begin
          state_d = ST_IDLE;
          err_inc = 1'b1;
        end else if (s1_data_q == PREAMBLE_BYTE) begin
          pre_cnt_d = (pre_cnt_q == PRE_CNT_MAX) ? pre_cnt_q : pre_cnt_q + 4'd1;
        end else if (s1_data_q == SFD_BYTE && pre_ok) begin
          state_d = ST_DATA;
          len_d   = 16'd0;
          first_d = 1'b1;
        end else begin
          state_d = ST_DROP;
          err_inc = 1'b1;
        end
      end

      ST_DATA: begin
        if (s1_ctrl_q) begin
          // The hold register delays by one byte so the last byte can carry eop.
          if (len_q != 16'd0) begin
            out_d.valid = 1'b1;
            out_d.data  = hold_q;
            out_d.sop   = first_q;
            first_d     = 1'b0;
          end
          hold_d = s1_data_q;
          len_d  = sat_inc16(len_q);
        end else begin
          state_d = ST_IDLE;
          if (len_q == 16'd0) begin
            err_inc = 1'b1;
          end else begin
            out_d.valid = 1'b1;
            out_d.data  = hold_q;
            out_d.sop   = first_q;
            out_d.eop   = 1'b1;
            out_d.err   = len_err;
            out_d.len   = len_q;
            first_d     = 1'b0;
            frame_inc   = 1'b1;
            err_inc     = len_err;
          end
        end
      end

      default: state_d = ST_DROP;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block order.
  always_ff @(posedge gmii_rxclk) begin
    if (rst) begin
      s1_ctrl_q <= 1'b0;
      s1_data_q <= 8'h00;
      s1_vld_q  <= 1'b0;
      state_q   <= ST_DROP;
      pre_cnt_q <= 4'd0;
      len_q     <= 16'd0;
      first_q   <= 1'b0;
      hold_q    <= 8'h00;
      out_q     <= '0;
    end else begin
      s1_ctrl_q <= gmii_rxctrl;
      s1_data_q <= gmii_rxdata;
      s1_vld_q  <= 1'b1;
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      len_q     <= len_d;
      first_q   <= first_d;
      hold_q    <= hold_d;
      out_q     <= out_d;
    end
  end

  gmii_rx_stats u_stats (
    .clk_i       (gmii_rxclk),
    .rst_i       (rst),
    .frame_inc_i (frame_inc),
    .err_inc_i   (err_inc),
    .frame_cnt_o (frame_cnt),
    .err_cnt_o   (err_cnt)
  );

  assign rx_valid = out_q.valid;
  assign rx_data  = out_q.data;
  assign rx_sop   = out_q.sop;
  assign rx_eop   = out_q.eop;
  assign rx_err   = out_q.err;
  assign rx_len   = out_q.len;

endmodule

// File: doc/gmii_rx_deframer.md
Name: gmii_rx_deframer

Overview:
- Synthesizable GMII receive-side deframer; the receiving end of the byte stream the team's GMII TX BFM drives.
- Samples gmii_rxctrl/gmii_rxdata and strips preamble and SFD.
- Emits frame payload as a byte stream with sop/eop, frame length and error flag.
- Keeps frame and error statistics. Sits between the PHY-facing GMII pins and the PTP timestamp/parser logic.

Parameters:
- SFD_BYTE, 8'h5D, start-of-frame delimiter value; matches the TX BFM. Set 8'hD5 for IEEE-ordered PHYs.
- MIN_PREAMBLE, 1, minimum number of 8'h55 bytes required before SFD.
- MIN_LEN, 14, payload bytes below this flag a runt error.
- MAX_LEN, 1522, payload bytes above this flag an oversize error.

Ports:
- gmii_rxclk  input  1  receive clock, 125 MHz; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- gmii_rxctrl  input  1  GMII receive data valid.
- gmii_rxdata  input  8  GMII receive byte.
- rx_valid  output  1  rx_data holds a payload byte this cycle.
- rx_data  output  8  payload byte.
- rx_sop  output  1  first payload byte of frame; qualified by rx_valid.
- rx_eop  output  1  last payload byte of frame; qualified by rx_valid.
- rx_err  output  1  frame error; valid only with rx_eop.
- rx_len  output  16  payload byte count; valid only with rx_eop.
- frame_cnt  output  32  frames delivered (good and errored).
- err_cnt  output  32  preamble/abort errors plus frames delivered with rx_err.

Behaviour:
- Reset (rst=1 at posedge): all outputs 0, counters 0, state DROP, pipeline registers cleared.
- Stage s1 registers gmii_rxctrl/gmii_rxdata. The FSM acts on s1 values.
- FSM states: DROP, IDLE, PREAMBLE, DATA.
- DROP:
  - s1 ctrl=0 -> IDLE.
  - Swallows the remainder of any frame in progress at reset release or after an error.
- IDLE:
  - ctrl=1 & data=8'h55 -> PREAMBLE, pre_cnt=1.
  - ctrl=1 & data=SFD_BYTE with MIN_PREAMBLE=0 -> DATA.
  - Any other ctrl=1 byte -> DROP, err_cnt+1.
- PREAMBLE:
  - 8'h55 -> pre_cnt+1, saturating at 15.
  - SFD_BYTE with pre_cnt>=MIN_PREAMBLE -> DATA, len=0, first=1.
  - SFD_BYTE with short preamble, or any other byte -> DROP, err_cnt+1.
  - ctrl=0 -> IDLE, err_cnt+1.
- DATA:
  - Each ctrl=1 byte is loaded into a one-byte hold register and len increments.
  - The previous hold byte is emitted on the outputs with rx_valid=1 and rx_sop=first; first then clears.
  - ctrl=0 -> hold byte emitted with rx_eop=1, rx_len=len, rx_err=(len<MIN_LEN)|(len>MAX_LEN); frame_cnt+1; err_cnt+1 if rx_err; -> IDLE.
  - ctrl=0 with len=0 (SFD immediately followed by idle) -> no output, err_cnt+1, -> IDLE.
- Single-byte frame: rx_sop and rx_eop are asserted together on the same cycle.
- Latency: fixed 3 clocks from a byte sampled on gmii_rxdata to its appearance on rx_data. Output is contiguous, one byte per cycle, no backpressure.
- len is 16-bit and saturates at 16'hFFFF; saturation implies oversize.
- Counters are 32-bit and wrap modulo 2^32.
- Outputs rx_sop/rx_eop/rx_err/rx_len are 0 whenever rx_valid=0.
- Back-to-back frames with a single idle cycle between them are accepted. ctrl=0 -> IDLE, and the next ctrl=1 byte is evaluated in IDLE on the following cycle.
- Reset mid-frame: outputs clear immediately. The partial frame produces no eop, and its remaining bytes are dropped (DROP) until ctrl=0.

Decomposition:
- Shared package gmii_pkg holds:
  - state enum (DROP, IDLE, PREAMBLE, DATA);
  - PREAMBLE_BYTE=8'h55;
  - defaults for SFD_BYTE, MIN_LEN and MAX_LEN.
- One natural sub-module, gmii_rx_stats: the two 32-bit wrapping counters with increment strobes. Everything else is a single module.

Test Plan:
- Good frame: 12 idle, 3x8'h55, SFD, bytes 8'h00..8'h3F (64) -> 64 rx_valid cycles, data 00..3F. rx_sop on 00, rx_eop on 3F, rx_len=64, rx_err=0, frame_cnt=1, err_cnt=0. First output 3 clocks after first payload byte.
- Runt: preamble+SFD+10 bytes -> 10 outputs, rx_eop with rx_len=10, rx_err=1; frame_cnt=1, err_cnt=1.
- Bad preamble: 8'h55,8'h55,8'hAA,then 20 bytes -> no rx_valid, err_cnt=1. Following good 64-byte frame received normally.
- Abort after SFD: preamble+SFD then ctrl=0 -> no rx_valid, frame_cnt=0, err_cnt=1.
- Reset mid-frame: rst high one cycle after payload byte 20 of 64, ctrl stays high -> outputs 0, no eop, remaining bytes ignored. Next frame delivered with rx_len=64, frame_cnt=1.
- Back-to-back: two 64-byte frames separated by one idle cycle -> two complete frames, frame_cnt=2, 2 eops, no errors. Single-byte frame gives rx_sop=rx_eop=1, rx_len=1, rx_err=1.
